// File: rtl/neuromorphic_bridge_pkg.sv
// Shared definitions for the neuromorphic ASIC bridge: decision FSM encoding
// and aux-channel geometry.
package neuromorphic_bridge_pkg;

  localparam int NUM_AUX_CH           = 4;
  localparam int CH_IDX_WIDTH         = 2;
  localparam int DEFAULT_SAMPLE_WIDTH = 12;

  typedef enum logic [1:0] {
    ST_ACC = 2'd0,
    ST_CMP = 2'd1,
    ST_DEC = 2'd2
  } wt_state_t;

endpackage

// File: rtl/aux_accumulator.sv
// Single-channel unsigned accumulator; clear has priority over add.
module aux_accumulator #(
  parameter int SAMPLE_WIDTH = 12,
  parameter int ACC_WIDTH    = 14
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_clr,
  input  logic                    i_add,
  input  logic [SAMPLE_WIDTH-1:0] i_sample,
  output logic [ACC_WIDTH-1:0]    o_acc
);

  logic [ACC_WIDTH-1:0] r_acc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc <= '0;
    end else if (i_clr) begin
      r_acc <= '0;
    end else if (i_add) begin
      r_acc <= r_acc + ACC_WIDTH'(i_sample);
    end
  end

  assign o_acc = r_acc;

endmodule

// File: rtl/aux_winner_tracker.sv
// Accumulates aux-channel frames per window, picks the arg-max channel and
// publishes it once the same winner has held for STABLE_COUNT windows.
module aux_winner_tracker
  import neuromorphic_bridge_pkg::*;
#(
  parameter int SAMPLE_WIDTH = DEFAULT_SAMPLE_WIDTH,
  parameter int AVG_LOG2     = 2,
  parameter int STABLE_COUNT = 3
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             sample_valid,
  input  logic [SAMPLE_WIDTH-1:0]          aux0,
  input  logic [SAMPLE_WIDTH-1:0]          aux1,
  input  logic [SAMPLE_WIDTH-1:0]          aux2,
  input  logic [SAMPLE_WIDTH-1:0]          aux3,
  input  logic                             clear,
  output logic [CH_IDX_WIDTH-1:0]          network_output,
  output logic                             result_valid,
  output logic                             busy,
  output logic [7:0]                       drop_count,
  output logic [SAMPLE_WIDTH+AVG_LOG2-1:0] winner_sum
);

  localparam int ACC_WIDTH = SAMPLE_WIDTH + AVG_LOG2;
  localparam int FCW       = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam logic [FCW-1:0] LAST_FRAME = FCW'((1 << AVG_LOG2) - 1);
  localparam logic [3:0] STABLE_MAX = 4'(STABLE_COUNT);

  wt_state_t r_state;
  wt_state_t w_state_nxt;

  logic [FCW-1:0]          r_frame_cnt;
  logic [CH_IDX_WIDTH-1:0] r_cmp_idx;
  logic [CH_IDX_WIDTH-1:0] r_best_idx;
  logic [ACC_WIDTH-1:0]    r_best_val;
  logic [CH_IDX_WIDTH-1:0] r_candidate;
  logic [3:0]              r_stable;
  logic                    r_pub_req;
  logic [CH_IDX_WIDTH-1:0] r_network_output;
  logic                    r_result_valid;
  logic [7:0]              r_drop_count;
  logic [ACC_WIDTH-1:0]    r_winner_sum;

  logic                    w_accept;
  logic                    w_last_frame;
  logic                    w_acc_clr;
  logic [SAMPLE_WIDTH-1:0] w_aux [NUM_AUX_CH];
  logic [ACC_WIDTH-1:0]    w_acc [NUM_AUX_CH];

  logic [CH_IDX_WIDTH-1:0] w_base_idx;
  logic [ACC_WIDTH-1:0]    w_base_val;
  logic [CH_IDX_WIDTH-1:0] w_best_idx_nxt;
  logic [ACC_WIDTH-1:0]    w_best_val_nxt;
  logic [CH_IDX_WIDTH-1:0] w_cand_nxt;
  logic [3:0]              w_stable_nxt;

  assign w_aux[0] = aux0;
  assign w_aux[1] = aux1;
  assign w_aux[2] = aux2;
  assign w_aux[3] = aux3;

  assign w_accept     = sample_valid && (r_state == ST_ACC) && !clear;
  assign w_last_frame = (r_frame_cnt == LAST_FRAME);
  assign w_acc_clr    = clear || (r_state == ST_DEC);

  for (genvar g = 0; g < NUM_AUX_CH; g++) begin : g_acc
    aux_accumulator #(
      .SAMPLE_WIDTH (SAMPLE_WIDTH),
      .ACC_WIDTH    (ACC_WIDTH)
    ) u_acc (
      .clk      (clk),
      .rst      (rst),
      .i_clr    (w_acc_clr),
      .i_add    (w_accept),
      .i_sample (w_aux[g]),
      .o_acc    (w_acc[g])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_ACC;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (clear) begin
      w_state_nxt = ST_ACC;
    end else begin
      case (r_state)
        ST_ACC:  if (w_accept && w_last_frame) w_state_nxt = ST_CMP;
        ST_CMP:  if (r_cmp_idx == 2'd3) w_state_nxt = ST_DEC;
        ST_DEC:  w_state_nxt = ST_ACC;
        default: w_state_nxt = ST_ACC;
      endcase
    end
  end

  // First compare step seeds the running best from acc0 directly, since
  // acc0 only settles on the edge that entered CMP.
  always_comb begin
    w_base_idx     = (r_cmp_idx == 2'd1) ? '0 : r_best_idx;
    w_base_val     = (r_cmp_idx == 2'd1) ? w_acc[0] : r_best_val;
    w_best_idx_nxt = w_base_idx;
    w_best_val_nxt = w_base_val;
    if (w_acc[r_cmp_idx] > w_base_val) begin
      w_best_idx_nxt = r_cmp_idx;
      w_best_val_nxt = w_acc[r_cmp_idx];
    end
  end

  always_comb begin
    w_cand_nxt   = r_best_idx;
    w_stable_nxt = 4'd1;
    if ((r_best_idx == r_candidate) && (r_stable != 4'd0)) begin
      w_cand_nxt   = r_candidate;
      w_stable_nxt = (r_stable >= STABLE_MAX) ? r_stable : r_stable + 4'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_frame_cnt      <= '0;
      r_cmp_idx        <= 2'd1;
      r_best_idx       <= '0;
      r_best_val       <= '0;
      r_candidate      <= '0;
      r_stable         <= '0;
      r_pub_req        <= 1'b0;
      r_network_output <= '0;
      r_result_valid   <= 1'b0;
      r_drop_count     <= '0;
      r_winner_sum     <= '0;
    end else if (clear) begin
      r_frame_cnt    <= '0;
      r_cmp_idx      <= 2'd1;
      r_candidate    <= '0;
      r_stable       <= '0;
      r_pub_req      <= 1'b0;
      r_result_valid <= 1'b0;
      r_drop_count   <= '0;
    end else begin
      r_result_valid <= r_pub_req;
      r_pub_req      <= 1'b0;
      if (r_pub_req) r_network_output <= r_candidate;
      if (sample_valid && (r_state != ST_ACC) && (r_drop_count != 8'hFF)) begin
        r_drop_count <= r_drop_count + 8'd1;
      end
      if (w_accept) r_frame_cnt <= w_last_frame ? '0 : r_frame_cnt + FCW'(1);
      case (r_state)
        ST_ACC: r_cmp_idx <= 2'd1;
        ST_CMP: begin
          r_best_idx <= w_best_idx_nxt;
          r_best_val <= w_best_val_nxt;
          r_cmp_idx  <= r_cmp_idx + 2'd1;
        end
        ST_DEC: begin
          r_candidate  <= w_cand_nxt;
          r_stable     <= w_stable_nxt;
          r_winner_sum <= r_best_val;
          r_pub_req    <= (w_stable_nxt >= STABLE_MAX);
        end
        default: r_cmp_idx <= 2'd1;
      endcase
    end
  end

  assign busy           = (r_state != ST_ACC);
  assign network_output = r_network_output;
  assign result_valid   = r_result_valid;
  assign drop_count     = r_drop_count;
  assign winner_sum     = r_winner_sum;

endmodule

// File: tb/tb_aux_winner_tracker.sv
// Directed bench for aux_winner_tracker with default parameters
// (SAMPLE_WIDTH=12, AVG_LOG2=2, STABLE_COUNT=3).
module tb_aux_winner_tracker;

  logic        clk;
  logic        rst;
  logic        sample_valid;
  logic [11:0] aux0, aux1, aux2, aux3;
  logic        clear;
  logic [1:0]  network_output;
  logic        result_valid;
  logic        busy;
  logic [7:0]  drop_count;
  logic [13:0] winner_sum;

  int total = 0;
  int bad   = 0;

  aux_winner_tracker dut (
    .clk            (clk),
    .rst            (rst),
    .sample_valid   (sample_valid),
    .aux0           (aux0),
    .aux1           (aux1),
    .aux2           (aux2),
    .aux3           (aux3),
    .clear          (clear),
    .network_output (network_output),
    .result_valid   (result_valid),
    .busy           (busy),
    .drop_count     (drop_count),
    .winner_sum     (winner_sum)
  );

  // clock / watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "bench timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  // All drivers start and end 1 time unit after a rising edge.
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [11:0] a, b, c, d);
    aux0 = a; aux1 = b; aux2 = c; aux3 = d;
    sample_valid = 1'b1;
    @(posedge clk);
    #1;
    sample_valid = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
  endtask

  // One full window; result_valid must appear exactly 5 edges after the last
  // sample and last a single cycle.
  task automatic run_window(input string tag, input logic [11:0] a, b, c, d,
                            input logic exp_rv, input logic [1:0] exp_no,
                            input logic [13:0] exp_ws);
    repeat (4) send(a, b, c, d);
    chk({tag, "_busy"}, 32'(busy), 32'd1);
    idle(4);
    chk({tag, "_rv_early"}, 32'(result_valid), 32'd0);
    idle(1);
    chk({tag, "_rv"}, 32'(result_valid), 32'(exp_rv));
    chk({tag, "_no"}, 32'(network_output), 32'(exp_no));
    chk({tag, "_ws"}, 32'(winner_sum), 32'(exp_ws));
    idle(1);
    chk({tag, "_rv_end"}, 32'(result_valid), 32'd0);
  endtask

  initial begin
    rst = 1'b1; clear = 1'b0; sample_valid = 1'b0;
    aux0 = '0; aux1 = '0; aux2 = '0; aux3 = '0;
    idle(2);
    chk("rst_no", 32'(network_output), 32'd0);
    chk("rst_rv", 32'(result_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_drop", 32'(drop_count), 32'd0);
    chk("rst_ws", 32'(winner_sum), 32'd0);
    rst = 1'b0;
    idle(1);

    // basic: channel 3 wins, published on the third window
    run_window("basic_w1", 12'd100, 12'd200, 12'd300, 12'd400, 1'b0, 2'd0, 14'd1600);
    run_window("basic_w2", 12'd100, 12'd200, 12'd300, 12'd400, 1'b0, 2'd0, 14'd1600);
    run_window("basic_w3", 12'd100, 12'd200, 12'd300, 12'd400, 1'b1, 2'd3, 14'd1600);

    // ties keep the lower index
    run_window("tie_w1", 12'd500, 12'd500, 12'd500, 12'd500, 1'b0, 2'd3, 14'd2000);
    run_window("tie_w2", 12'd500, 12'd500, 12'd500, 12'd500, 1'b0, 2'd3, 14'd2000);
    run_window("tie_w3", 12'd500, 12'd500, 12'd500, 12'd500, 1'b1, 2'd0, 14'd2000);
    run_window("tie2_w1", 12'd500, 12'd500, 12'd501, 12'd501, 1'b0, 2'd0, 14'd2004);
    run_window("tie2_w2", 12'd500, 12'd500, 12'd501, 12'd501, 1'b0, 2'd0, 14'd2004);
    run_window("tie2_w3", 12'd500, 12'd500, 12'd501, 12'd501, 1'b1, 2'd2, 14'd2004);

    // alternating winners never publish
    do_clear();
    chk("clr_no_kept", 32'(network_output), 32'd2);
    for (int i = 0; i < 4; i++) begin
      run_window("alt_a", 12'd0, 12'd0, 12'd10, 12'd0, 1'b0, 2'd2, 14'd40);
      run_window("alt_b", 12'd0, 12'd10, 12'd0, 12'd0, 1'b0, 2'd2, 14'd40);
    end
    run_window("one_w1", 12'd0, 12'd10, 12'd0, 12'd0, 1'b0, 2'd2, 14'd40);
    run_window("one_w2", 12'd0, 12'd10, 12'd0, 12'd0, 1'b1, 2'd1, 14'd40);
    run_window("one_w3", 12'd0, 12'd10, 12'd0, 12'd0, 1'b1, 2'd1, 14'd40);

    // strobes during the 4 busy cycles are dropped and not accumulated
    do_clear();
    repeat (4) send(12'd5, 12'd6, 12'd7, 12'd8);
    repeat (4) send(12'd1000, 12'd0, 12'd0, 12'd0);
    chk("drop4_cnt", 32'(drop_count), 32'd4);
    chk("drop4_ws", 32'(winner_sum), 32'd32);
    idle(1);
    chk("drop4_rv", 32'(result_valid), 32'd0);
    idle(1);
    run_window("after_drop", 12'd1, 12'd2, 12'd3, 12'd4, 1'b0, 2'd1, 14'd16);

    // continuous strobes: half are dropped, count saturates
    aux0 = 12'd1; aux1 = 12'd1; aux2 = 12'd1; aux3 = 12'd1;
    sample_valid = 1'b1;
    idle(600);
    sample_valid = 1'b0;
    chk("drop_sat", 32'(drop_count), 32'd255);
    chk("sat_no", 32'(network_output), 32'd0);
    do_clear();
    chk("clr_drop", 32'(drop_count), 32'd0);
    chk("clr_busy", 32'(busy), 32'd0);
    chk("clr_rv", 32'(result_valid), 32'd0);

    // full-scale sums do not wrap
    run_window("max", 12'd4095, 12'd4095, 12'd4095, 12'd4095, 1'b0, 2'd0, 14'd16380);

    // clear mid-window discards earlier frames; a fresh 4 frames are needed
    repeat (2) send(12'd4095, 12'd4095, 12'd4095, 12'd4095);
    do_clear();
    repeat (3) send(12'd1, 12'd2, 12'd3, 12'd9);
    chk("clrwin_busy3", 32'(busy), 32'd0);
    chk("clrwin_drop", 32'(drop_count), 32'd0);
    send(12'd1, 12'd2, 12'd3, 12'd9);
    chk("clrwin_busy4", 32'(busy), 32'd1);
    idle(4);
    chk("clrwin_ws", 32'(winner_sum), 32'd36);
    idle(1);
    chk("clrwin_rv", 32'(result_valid), 32'd0);
    idle(1);

    // asynchronous reset in the middle of CMP
    repeat (4) send(12'd0, 12'd0, 12'd0, 12'd7);
    idle(1);
    chk("mid_busy_pre", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    chk("mid_rst_no", 32'(network_output), 32'd0);
    chk("mid_rst_ws", 32'(winner_sum), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_rv", 32'(result_valid), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(1);
    run_window("post_rst_w1", 12'd0, 12'd0, 12'd0, 12'd7, 1'b0, 2'd0, 14'd28);
    run_window("post_rst_w2", 12'd0, 12'd0, 12'd0, 12'd7, 1'b0, 2'd0, 14'd28);
    run_window("post_rst_w3", 12'd0, 12'd0, 12'd0, 12'd7, 1'b1, 2'd3, 14'd28);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/aux_winner_tracker.md
Name: aux_winner_tracker

Overview:
- Consumes the four 12-bit XADC auxiliary-channel measurements of the neuromorphic ASIC output neurons, one frame per strobe from the XADC DRP reader.
- Accumulates 2^AVG_LOG2 frames per channel, then finds the winning channel with a sequential arg-max.
- Applies a stability filter before publishing the classified character as network_output to the AXI config register block and the LED/debug muxing.

Parameters:
SAMPLE_WIDTH, 12, width of each aux measurement
AVG_LOG2, 2, log2 of frames accumulated per decision window (0..8)
STABLE_COUNT, 3, consecutive identical window winners required before network_output updates (1..15)
ACC_WIDTH, SAMPLE_WIDTH+AVG_LOG2, derived localparam; accumulator width, cannot overflow

Ports:
clk  in  1  system clock (AXI clock domain)
rst  in  1  asynchronous active-high reset
sample_valid  in  1  one-cycle strobe; aux0..aux3 hold a complete new frame
aux0  in  SAMPLE_WIDTH  measured AUX channel 0
aux1  in  SAMPLE_WIDTH  measured AUX channel 1
aux2  in  SAMPLE_WIDTH  measured AUX channel 2
aux3  in  SAMPLE_WIDTH  measured AUX channel 3
clear  in  1  synchronous restart of the decision pipeline
network_output  out  2  published winning channel index
result_valid  out  1  one-cycle pulse on each published decision
busy  out  1  high while comparing/deciding; samples ignored
drop_count  out  8  saturating count of sample_valid strobes ignored while busy
winner_sum  out  ACC_WIDTH  accumulated sum of the last evaluated window's winner

Behaviour:
- Interface: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values: all outputs are 0. Internal state: ACC, accumulators 0, frame counter 0, stable counter 0, candidate 0.
- States:
  - ACC: each sample_valid adds aux0..3 into acc0..3 and increments the frame counter.
  - On the sample_valid that completes 2^AVG_LOG2 frames, the add still occurs, the frame counter wraps to 0, and the next state is CMP.
- CMP: lasts exactly 3 cycles, index i = 1,2,3.
  - best_idx starts at 0, best_val at acc0.
  - Each cycle, if acc_i > best_val (strict), best takes i.
  - Ties keep the lower index.
- DEC: lasts 1 cycle.
  - If best_idx == candidate and the stable counter is nonzero, the stable counter increments, saturating at STABLE_COUNT.
  - Otherwise candidate takes best_idx and the stable counter takes 1.
  - winner_sum takes best_val.
  - Accumulators clear.
  - Next state is ACC.
- Publish: registered at the DEC exit edge. If the updated stable counter is at least STABLE_COUNT, network_output takes candidate and result_valid pulses for 1 cycle. A pulse also occurs on every subsequent matching window.
- Latency: last sample_valid sampled at edge k; result_valid and the new network_output are high from edge k+5.
- Busy: busy = (state != ACC). sample_valid while busy is ignored and drop_count increments, saturating at 255.
- clear:
  - Wins over sample_valid and aborts CMP/DEC.
  - Next state is ACC. Accumulators, frame counter, stable counter, candidate and drop_count all go to 0.
  - network_output and winner_sum are retained. result_valid is 0.
- Reset mid-operation: immediate return to reset values; no partial publish.
- Arithmetic: unsigned throughout. Maximum sum (2^SAMPLE_WIDTH-1)·2^AVG_LOG2 fits ACC_WIDTH exactly.

Decomposition:
- Shared package neuromorphic_bridge_pkg holds:
  - state encoding (ACC, CMP, DEC)
  - NUM_AUX_CH = 4
  - CH_IDX_WIDTH = 2
  - default SAMPLE_WIDTH
- One natural sub-module, aux_accumulator: a single-channel ACC_WIDTH accumulator with add/clear controls, instantiated 4 times.
- The FSM, comparator and stability filter stay in the top of this block.

Test Plan:
- Reset with rst asserted mid-CMP → all outputs 0 immediately; the next full window starts from frame 0 with no spurious result_valid.
- AVG_LOG2=2, STABLE_COUNT=3; 12 strobes of aux=(100,200,300,400):
  - no pulse after strobes 4 and 8
  - after the 12th strobe: network_output=3, winner_sum=1600, result_valid high exactly 5 cycles later for 1 cycle
- Ties: all channels 500 for 3 windows → network_output=0. Then aux=(500,500,501,501) for 3 windows → network_output=2.
- Alternating windows: winner 2, 1, 2, 1, ... for 8 windows → no result_valid and network_output unchanged. Then 3 consecutive winner-1 windows → network_output=1.
- sample_valid asserted on all 4 busy cycles after a window completes:
  - drop_count=4
  - the next window's sums exclude the dropped frames
  - 300 busy-cycle strobes → drop_count saturates at 255
- All channels 4095 for 4 frames → winner_sum=16380, no wrap. Then clear after 2 frames of a new window → 4 further frames are needed before CMP, and drop_count=0.
